// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Signal bundle between the two requesters/RAM (master) and the arbiter (slave).
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  import data_mem_arbiter_pkg::*;

  // Handshake: req[n] with its addr/we/be/wdata is held until gnt[n] is seen in
  // the same cycle; rvalid[n] follows exactly one cycle after each grant.
  logic [1:0]                      req;
  logic [1:0][ADDR_WIDTH-1:0]      addr;
  logic [1:0]                      we;
  logic [1:0][DATA_WIDTH/8-1:0]    be;
  logic [1:0][DATA_WIDTH-1:0]      wdata;
  logic [1:0]                      gnt;
  logic [1:0]                      rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            mem_en;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_we;
  logic [DATA_WIDTH/8-1:0]         mem_be;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport master (
    output req, addr, we, be, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    input  req, addr, we, be, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_addr, mem_we, mem_be, mem_wdata
  );

endinterface

// File: rtl/data_mem_arb_pick.sv
// Two-way picker: the port named by prio_i wins a tie; output is one-hot or zero.
module data_mem_arb_pick (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[prio_i]) begin
      gnt_o[prio_i] = 1'b1;
    end else if (req_i[~prio_i]) begin
      gnt_o[~prio_i] = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port write-first RAM, 1-cycle response.
// Define DATA_MEM_ARB_RR_EN for round-robin; otherwise fixed priority with starvation limit.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            rstn_i,
  input  logic [1:0]                      req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]      addr_i,
  input  logic [1:0]                      we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]    be_i,
  input  logic [1:0][DATA_WIDTH-1:0]      wdata_i,
  output logic [1:0]                      gnt_o,
  output logic [1:0]                      rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            mem_en_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic                            mem_we_o,
  output logic [DATA_WIDTH/8-1:0]         mem_be_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  logic       prio_hint;
  logic [1:0] pick_gnt;
  rsp_t       rsp_q, rsp_d;
  logic       rd_q, rd_d;

`ifdef DATA_MEM_ARB_RR_EN
  // last_q = port that won most recently; the other port gets the next tie.
  logic last_q, last_d;

  assign prio_hint = ~last_q;

  always_comb begin
    last_d = last_q;
    if (gnt_o[PORT_DBG]) begin
      last_d = 1'b1;
    end else if (gnt_o[PORT_CORE]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign prio_hint = (starve_q == LIMIT);

  // Counts core wins while debug waits; saturating so it can never wrap back to 0.
  always_comb begin
    starve_d = starve_q;
    if (gnt_o[PORT_DBG] || !req_i[PORT_DBG]) begin
      starve_d = '0;
    end else if (gnt_o[PORT_CORE] && (starve_q != {CNT_W{1'b1}})) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  data_mem_arb_pick u_pick (
    .req_i  (req_i),
    .prio_i (prio_hint),
    .gnt_o  (pick_gnt)
  );

  assign gnt_o = rstn_i ? pick_gnt : 2'b00;

  always_comb begin
    mem_en_o    = |gnt_o;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_o[PORT_DBG]) begin
      mem_addr_o  = addr_i[PORT_DBG];
      mem_we_o    = we_i[PORT_DBG];
      mem_be_o    = be_i[PORT_DBG];
      mem_wdata_o = wdata_i[PORT_DBG];
    end else if (gnt_o[PORT_CORE]) begin
      mem_addr_o  = addr_i[PORT_CORE];
      mem_we_o    = we_i[PORT_CORE];
      mem_be_o    = be_i[PORT_CORE];
      mem_wdata_o = wdata_i[PORT_CORE];
    end
  end

  always_comb begin
    rsp_d.valid = |gnt_o;
    rsp_d.owner = gnt_o[PORT_DBG];
    rd_d        = (|gnt_o) & ~mem_we_o;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      rd_q  <= rd_d;
    end
  end

  always_comb begin
    rvalid_o               = 2'b00;
    rvalid_o[rsp_q.owner]  = rsp_q.valid;
  end

  // Write responses carry no data; only read responses expose the RAM output.
  assign rdata_o = (rsp_q.valid && rd_q) ? mem_rdata_i : '0;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, byte-address width shared by both ports and the RAM.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, max consecutive port-0 grants while port 1 waits.
REQ-004 The block SHALL have port clk, input, 1, the single clock (rising edge).
REQ-005 The block SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req_i, input, [1:0], per-port access request (port 0 = core LSU, port 1 = debug/DMA).
REQ-007 The block SHALL have port addr_i, input, [1:0][ADDR_WIDTH-1:0], per-port byte address.
REQ-008 The block SHALL have port we_i, input, [1:0], per-port write enable.
REQ-009 The block SHALL have port be_i, input, [1:0][DATA_WIDTH/8-1:0], per-port byte enables.
REQ-010 The block SHALL have port wdata_i, input, [1:0][DATA_WIDTH-1:0], per-port write data.
REQ-011 The block SHALL have port gnt_o, output, [1:0], per-port grant, one-hot or zero.
REQ-012 The block SHALL have port rvalid_o, output, [1:0], per-port response valid.
REQ-013 The block SHALL have port rdata_o, output, [DATA_WIDTH-1:0], response data, shared by both ports and qualified by rvalid_o.
REQ-014 The block SHALL have port mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, outputs, RAM-side copies of the granted port's request.
REQ-015 The block SHALL have port mem_rdata_i, input, [DATA_WIDTH-1:0], RAM read data, valid one cycle after mem_en_o.

Function
REQ-016 The block SHALL compute grant combinationally in the request cycle: gnt_o[n] = req_i[n] and port n wins arbitration; at most one bit set.
REQ-017 The block SHALL drive mem_en_o = |gnt_o and mux mem_addr/we/be/wdata from the granted port; otherwise the mem_* outputs are zero.
REQ-018 The block SHALL register the granted port index (owner) and a pending flag at each grant; in the following cycle it SHALL assert rvalid_o[owner] for exactly one cycle for both reads and writes.
REQ-019 The block SHALL pass rdata_o = mem_rdata_i whenever rvalid_o is set, and drive zero for writes and idle cycles.
REQ-020 The block SHALL support back-to-back grants every cycle, giving a throughput of one access per cycle and a fixed latency of 1 cycle from grant to rvalid.
REQ-021 Fixed-priority mode: port 0 SHALL win; a 3-bit-min counter SHALL count consecutive port-0 grants while req_i[1] is high; when it equals STARVE_LIMIT, port 1 SHALL be granted next and the counter SHALL clear.
REQ-022 The counter SHALL clear on any port-1 grant or any cycle with req_i[1] low, and SHALL saturate rather than wrap.
REQ-023 Requests on a port SHALL remain stable until granted; the block SHALL NOT check this.
REQ-024 A write and a read to the same address in consecutive cycles SHALL return the newly written data, because the RAM is write-first.

Reset
REQ-025 While rstn_i is low, gnt_o, rvalid_o, rdata_o, mem_* outputs, owner, pending flag, starvation counter and RR pointer SHALL be 0.
REQ-026 A reset asserted mid-access SHALL drop the pending response; no rvalid_o is issued after rstn_i rises.

Configuration
REQ-027 With macro DATA_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit last-winner pointer applies, with port 1 winning the first tie after reset (pointer=0 means port 0 won last), and the STARVE_LIMIT counter is absent.
REQ-028 With DATA_MEM_ARB_RR_EN undefined, the fixed-priority rules of REQ-021/022 SHALL apply.

Structure
REQ-029 The shared package SHALL hold the port index constants PORT_CORE=0 and PORT_DBG=1 and the response struct type (valid, owner).
REQ-030 The design SHALL have one sub-module, data_mem_arb_pick, a 2-way picker taking the requests and a priority hint and returning a one-hot grant.

Verification
REQ-031 Single read: p0 req addr 0x10 after mem holds 0xDEADBEEF -> gnt_o=01 same cycle, rvalid_o=01 next cycle, rdata_o=0xDEADBEEF.
REQ-032 Simultaneous requests, fixed priority: both ports request continuously -> port 0 granted 4 times, then port 1 once, repeating.
REQ-033 Simultaneous requests, RR build: both ports request continuously -> grants alternate 10,01,10,... starting with port 1.
REQ-034 Byte write: p1 we be=0010 wdata=0x0000AB00 addr 0x20, then p0 read 0x20 -> byte 1 = 0xAB, other bytes unchanged, rvalid routed to p1 then p0.
REQ-035 Reset mid-access: rstn_i low in the cycle after a grant -> rvalid_o stays 00; first post-reset grant behaves as REQ-031.
